// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - width limits and Gray/binary conversion functions shared by the Gray counters
package gray_pkg;

  localparam int GRAY_WMIN = 2;
  localparam int GRAY_WMAX = 16;

  // Operands are zero-extended to GRAY_WMAX; callers truncate back to their own width.
  function automatic logic [GRAY_WMAX-1:0] bin2gray(input logic [GRAY_WMAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_WMAX-1:0] gray2bin(input logic [GRAY_WMAX-1:0] g);
    logic [GRAY_WMAX-1:0] b;
    b[GRAY_WMAX-1] = g[GRAY_WMAX-1];
    for (int i = GRAY_WMAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// rtl/gray_conv.sv - combinational Gray-to-binary converter of parametrised width
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(gray2bin(GRAY_WMAX'(gray_i)));

endmodule

// File: rtl/gray_updown.sv
// rtl/gray_updown.sv - loadable up/down Gray counter with sticky wrap flags and a wrap pulse
module gray_updown
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             wrap_o
);

  if (WIDTH < GRAY_WMIN || WIDTH > GRAY_WMAX) begin : g_width_check
    $error("gray_updown: WIDTH out of range");
  end

  logic [WIDTH-1:0] gray_q, gray_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] bin_cur;
  logic [WIDTH-1:0] bin_step;

  // One converter serves both the BinOut port and the count arithmetic.
  gray_conv #(
    .WIDTH(WIDTH)
  ) u_conv (
    .gray_i(gray_q),
    .bin_o (bin_cur)
  );

  always_comb begin
    gray_d      = gray_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wrap_d      = 1'b0;
    bin_step    = bin_cur;
    if (load_i) begin
      gray_d = WIDTH'(bin2gray(GRAY_WMAX'(load_val_i)));
    end else if (en_i) begin
      if (up_i) begin
        bin_step = bin_cur + 1'b1;
        if (bin_cur == '1) begin
          overflow_d = 1'b1;
          wrap_d     = 1'b1;
        end
      end else begin
        bin_step = bin_cur - 1'b1;
        if (bin_cur == '0) begin
          underflow_d = 1'b1;
          wrap_d      = 1'b1;
        end
      end
      gray_d = WIDTH'(bin2gray(GRAY_WMAX'(bin_step)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gray_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      gray_q      <= gray_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      wrap_q      <= wrap_d;
    end
  end

  assign gray_o      = gray_q;
  assign bin_o       = bin_cur;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_gray_updown.sv
// tb/tb_gray_updown.sv - randomized and directed checks of gray_updown at WIDTH 3 and 4
module tb_gray_updown;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       ld = 1'b0;
  logic [2:0] lv3 = '0;
  logic [3:0] lv4 = '0;

  logic [2:0] g3, b3;
  logic [3:0] g4, b4;
  logic       ovf3, unf3, wrp3, ovf4, unf4, wrp4;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gray_updown #(.WIDTH(3)) dut3 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .up_i(up), .load_i(ld), .load_val_i(lv3),
    .gray_o(g3), .bin_o(b3), .overflow_o(ovf3), .underflow_o(unf3), .wrap_o(wrp3)
  );

  gray_updown #(.WIDTH(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .up_i(up), .load_i(ld), .load_val_i(lv4),
    .gray_o(g4), .bin_o(b4), .overflow_o(ovf4), .underflow_o(unf4), .wrap_o(wrp4)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int maxv(input int i);
    return (i == 0) ? 7 : 15;
  endfunction

  function automatic int lval(input int i);
    return (i == 0) ? int'(lv3) : int'(lv4);
  endfunction

  function automatic int dgray(input int i);
    return (i == 0) ? int'(g3) : int'(g4);
  endfunction

  // Reference: the count is kept as a plain integer; Gray is derived from it only at check time.
  int m_bin[2];
  bit m_ovf[2], m_unf[2], m_wrap[2], m_step[2];
  int m_prev[2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    m_valid <= m_valid | rst;
    for (int i = 0; i < 2; i++) begin
      m_step[i] <= !rst && !ld && en;
      m_prev[i] <= dgray(i);
      if (rst) begin
        m_bin[i]  <= 0;
        m_ovf[i]  <= 1'b0;
        m_unf[i]  <= 1'b0;
        m_wrap[i] <= 1'b0;
      end else if (ld) begin
        m_bin[i]  <= lval(i);
        m_wrap[i] <= 1'b0;
      end else if (en && up) begin
        m_bin[i]  <= (m_bin[i] + 1) % (maxv(i) + 1);
        m_wrap[i] <= (m_bin[i] == maxv(i));
        if (m_bin[i] == maxv(i)) m_ovf[i] <= 1'b1;
      end else if (en) begin
        m_bin[i]  <= (m_bin[i] + maxv(i)) % (maxv(i) + 1);
        m_wrap[i] <= (m_bin[i] == 0);
        if (m_bin[i] == 0) m_unf[i] <= 1'b1;
      end else begin
        m_wrap[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("w3_gray", int'(g3), m_bin[0] ^ (m_bin[0] >> 1));
      chk("w3_bin", int'(b3), m_bin[0]);
      chk("w3_ovf", int'(ovf3), int'(m_ovf[0]));
      chk("w3_unf", int'(unf3), int'(m_unf[0]));
      chk("w3_wrap", int'(wrp3), int'(m_wrap[0]));
      chk("w4_gray", int'(g4), m_bin[1] ^ (m_bin[1] >> 1));
      chk("w4_bin", int'(b4), m_bin[1]);
      chk("w4_ovf", int'(ovf4), int'(m_ovf[1]));
      chk("w4_unf", int'(unf4), int'(m_unf[1]));
      chk("w4_wrap", int'(wrp4), int'(m_wrap[1]));
      if (m_step[0]) chk("w3_onebit", $countones(m_prev[0] ^ int'(g3)), 1);
      if (m_step[1]) chk("w4_onebit", $countones(m_prev[1] ^ int'(g4)), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int seq3[8];
    seq3 = '{1, 3, 2, 6, 7, 5, 4, 0};

    do_reset();
    chk("rst_gray", int'(g3), 0);
    chk("rst_bin", int'(b3), 0);
    chk("rst_flags", int'({ovf3, unf3, wrp3}), 0);

    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("up8_gray", int'(g3), seq3[k]);
      chk("up8_ovf", int'(ovf3), (k == 7) ? 1 : 0);
      chk("up8_wrap", int'(wrp3), (k == 7) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    chk("up8_wrap_end", int'(wrp3), 0);

    do_reset();
    en = 1'b1; up = 1'b0;
    tick();
    chk("dn1_gray", int'(g3), 3'b100);
    chk("dn1_bin", int'(b3), 7);
    chk("dn1_unf", int'(unf3), 1);
    chk("dn1_ovf", int'(ovf3), 0);
    chk("dn1_wrap", int'(wrp3), 1);
    en = 1'b0;
    tick();
    chk("dn1_wrap_end", int'(wrp3), 0);

    do_reset();
    ld = 1'b1; lv3 = 3'd5; en = 1'b0;
    tick();
    chk("ld5_gray", int'(g3), 3'b111);
    chk("ld5_bin", int'(b3), 5);
    ld = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("ld5_inc", int'(g3), 3'b101);

    do_reset();
    ld = 1'b1; lv3 = 3'd7; en = 1'b0;
    tick();
    lv3 = 3'd2; en = 1'b1; up = 1'b1;
    tick();
    chk("ldwrap_gray", int'(g3), 3'b011);
    chk("ldwrap_ovf", int'(ovf3), 0);
    chk("ldwrap_wrap", int'(wrp3), 0);
    ld = 1'b0;

    do_reset();
    en = 1'b1; up = 1'b1;
    repeat (4) tick();
    chk("pre_rst_gray", int'(g3), 3'b110);
    rst = 1'b1; ld = 1'b1; lv3 = 3'd5;
    tick();
    chk("rstld_gray", int'(g3), 0);
    chk("rstld_flags", int'({ovf3, unf3, wrp3}), 0);
    rst = 1'b0; ld = 1'b0; en = 1'b0;
    repeat (100) tick();
    chk("idle_gray", int'(g3), 0);

    do_reset();
    en = 1'b1; up = 1'b1;
    repeat (32) tick();
    up = 1'b0;
    repeat (32) tick();
    chk("w4_final_bin", int'(b4), 0);
    chk("w4_final_ovf", int'(ovf4), 1);
    chk("w4_final_unf", int'(unf4), 1);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 5) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = $urandom_range(0, 1) != 0;
      lv3 = 3'($urandom_range(0, 7));
      lv4 = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; ld = 1'b0; en = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
